dibit_tx_serializer: RTL and testbench

//  Transmit side of the 2-bit symbol stream consumed by the sys_clk-domain lab blocks.

---
 rtl/dibit_tx_serializer.sv | 116 +++++++++++
 tb/tb_dibit_tx_serializer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dibit_tx_serializer.sv
// Purpose : serialize DATA_W-bit words MSB-first into 2-bit symbols paced by sym_en.
// Latency : first symbol registered on out one cycle after accept; back-to-back words stream gap-free.
// Backpr. : din_ready is 1 in IDLE, or on the sym_en edge that retires the last symbol; otherwise 0.
module dibit_tx_serializer #(
   parameter int         DATA_W   = 8,
   parameter logic [1:0] IDLE_SYM = 2'b00,
   parameter int         CNT_W    = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic              sym_en,
   output logic [1:0]        out,
   output logic              out_valid,
   output logic              busy,
   output logic [CNT_W-1:0]  byte_cnt
);

   localparam int SYMS  = DATA_W / 2;
   localparam int IDX_W = (SYMS > 1) ? $clog2(SYMS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [IDX_W-1:0]  sym_idx_q, sym_idx_d;
   logic [1:0]        out_q, out_d;
   logic              out_valid_q, out_valid_d;
   logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic              last_sym;
   logic              accept;
   logic              load;

   // Symbol k of a word: bits [DATA_W-1-2k : DATA_W-2-2k].
   function automatic logic [1:0] sym_of(input logic [DATA_W-1:0] w, input int k);
      logic [DATA_W-1:0] s;
      s = w >> (DATA_W - 2 - 2 * k);
      return s[1:0];
   endfunction

   // Handshake: a retiring strobe frees the holding register in the same cycle.
   always_comb begin
      last_sym  = (sym_idx_q == LAST_IDX);
      din_ready = sys_rst_n & ((state_q == IDLE) | (sym_en & last_sym));
      accept    = din_valid & din_ready;
   end

   // Next-state: load on accept, advance on sym_en, retire to IDLE when nothing follows.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      sym_idx_d   = sym_idx_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      byte_cnt_d  = byte_cnt_q;
      load        = 1'b0;
      case (state_q)
         IDLE: begin
            load = accept;
         end
         SHIFT: begin
            if (sym_en) begin
               if (last_sym) begin
                  byte_cnt_d = byte_cnt_q + CNT_W'(1);
                  if (accept) begin
                     load = 1'b1;
                  end else begin
                     state_d     = IDLE;
                     out_d       = IDLE_SYM;
                     out_valid_d = 1'b0;
                     sym_idx_d   = '0;
                  end
               end else begin
                  sym_idx_d = sym_idx_q + 1'b1;
                  out_d     = sym_of(shreg_q, int'(sym_idx_q) + 1);
               end
            end
         end
      endcase
      if (load) begin
         state_d     = SHIFT;
         shreg_d     = din;
         out_d       = din[DATA_W-1 -: 2];
         out_valid_d = 1'b1;
         sym_idx_d   = '0;
      end
   end

   // State registers; reset discards any word in flight without counting it.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         sym_idx_q   <= '0;
         out_q       <= IDLE_SYM;
         out_valid_q <= 1'b0;
         byte_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         sym_idx_q   <= sym_idx_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         byte_cnt_q  <= byte_cnt_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q == SHIFT);
   assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_dibit_tx_serializer.sv
// Bench for dibit_tx_serializer: an 8-bit-counter instance and a 2-bit-counter instance
// share the same stimulus; a queue of expected symbols predicts out/out_valid/din_ready.
// Cycle table for back-to-back words, hand sequences for pacing, reset and wrap.
module tb_dibit_tx_serializer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din = '0;
   logic       din_valid = 1'b0;
   logic       sym_en = 1'b0;

   logic       din_ready, out_valid, busy;
   logic [1:0] out;
   logic [7:0] byte_cnt;
   logic       din_ready2, out_valid2, busy2;
   logic [1:0] out2;
   logic [1:0] byte_cnt2;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_cnt = 0;

   typedef struct {
      logic [1:0] sym;
      bit         last;
   } sb_t;
   sb_t q[$];

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       en;
      logic [1:0] e_out;
      logic       e_ov;
      logic       e_rdy;
      logic [7:0] e_cnt;
   } vec_t;
   vec_t tbl[10];

   always #5 clk = ~clk;

   dibit_tx_serializer #(.DATA_W(8), .IDLE_SYM(2'b00), .CNT_W(8)) dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .sym_en(sym_en), .out(out), .out_valid(out_valid),
      .busy(busy), .byte_cnt(byte_cnt));

   dibit_tx_serializer #(.DATA_W(8), .IDLE_SYM(2'b00), .CNT_W(2)) dut2 (
      .sys_clk(clk), .sys_rst_n(rst_n), .din(din), .din_valid(din_valid),
      .din_ready(din_ready2), .sym_en(sym_en), .out(out2), .out_valid(out_valid2),
      .busy(busy2), .byte_cnt(byte_cnt2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [7:0] w);
      for (int k = 0; k < 4; k++) begin
         sb_t s;
         s.sym  = w[7-2*k -: 2];
         s.last = (k == 3);
         q.push_back(s);
      end
   endtask

   function automatic logic model_rdy();
      return rst_n && (q.size() == 0 || (sym_en && q.size() == 1));
   endfunction

   // One clock: check at negedge against the queue model, then account for the coming edge.
   task automatic cycle(input bit use_v, input vec_t v);
      logic       e_rdy;
      logic [1:0] e_out;
      sb_t        s;
      @(negedge clk);
      e_rdy = model_rdy();
      e_out = 2'b00;
      if (q.size() != 0) e_out = q[0].sym;
      chk("din_ready", din_ready, e_rdy);
      chk("busy", busy, q.size() != 0);
      chk("out_valid", out_valid, q.size() != 0);
      chk("out", out, e_out);
      chk("byte_cnt", byte_cnt, exp_cnt[7:0]);
      chk("byte_cnt_w2", byte_cnt2, exp_cnt[1:0]);
      chk("out_w2", out2, e_out);
      if (use_v) begin
         chk("tbl_out", out, v.e_out);
         chk("tbl_out_valid", out_valid, v.e_ov);
         chk("tbl_din_ready", din_ready, v.e_rdy);
         chk("tbl_byte_cnt", byte_cnt, v.e_cnt);
      end
      if (sym_en && q.size() != 0) begin
         s = q.pop_front();
         if (s.last) exp_cnt++;
      end
      if (din_valid && e_rdy) push_word(din);
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      vec_t z;
      z = '{default: '0};
      cycle(1'b0, z);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      q.delete();
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit acc;
      // B4 = 2,3,1,0 then 1E = 0,1,3,2 held valid, full rate
      tbl[0] = '{1'b1, 8'hB4, 1'b1, 2'd0, 1'b0, 1'b1, 8'd0};
      tbl[1] = '{1'b1, 8'h1E, 1'b1, 2'd2, 1'b1, 1'b0, 8'd0};
      tbl[2] = '{1'b1, 8'h1E, 1'b1, 2'd3, 1'b1, 1'b0, 8'd0};
      tbl[3] = '{1'b1, 8'h1E, 1'b1, 2'd1, 1'b1, 1'b0, 8'd0};
      tbl[4] = '{1'b1, 8'h1E, 1'b1, 2'd0, 1'b1, 1'b1, 8'd0};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 1'b0, 8'd1};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 1'b0, 8'd1};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 2'd3, 1'b1, 1'b0, 8'd1};
      tbl[8] = '{1'b0, 8'h00, 1'b1, 2'd2, 1'b1, 1'b1, 8'd1};
      tbl[9] = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1, 8'd2};

      // Held in reset with valid asserted: nothing may be accepted.
      din_valid = 1'b1;
      din = 8'hA5;
      sym_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_din_ready", din_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out", out, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_byte_cnt", byte_cnt, 8'd0);
      din_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Idle with strobes running: no output, no count.
      for (int i = 0; i < 10; i++) tick();

      // Back-to-back table.
      for (int i = 0; i < 10; i++) begin
         din_valid = tbl[i].v;
         din       = tbl[i].d;
         sym_en    = tbl[i].en;
         cycle(1'b1, tbl[i]);
      end

      // Single word at full rate.
      din = 8'hB4;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      din = 8'h3C;
      for (int i = 0; i < 6; i++) tick();
      chk("single_cnt", byte_cnt, 8'd3);

      // Paced output: strobe every 3rd cycle, C9 = 3,0,2,1 each held 3 cycles.
      sym_en = 1'b0;
      din = 8'hC9;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < 14; i++) begin
         sym_en = (i % 3 == 2);
         tick();
      end
      chk("paced_cnt", byte_cnt, 8'd4);

      // Async reset during the second symbol of FF.
      sym_en = 1'b1;
      din = 8'hFF;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out", out, 2'b00);
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_din_ready", din_ready, 1'b0);
      chk("arst_byte_cnt", byte_cnt, 8'd0);
      chk("arst_byte_cnt_w2", byte_cnt2, 2'd0);
      q.delete();
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      din = 8'h55;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("post_rst_cnt", byte_cnt, 8'd1);

      // Five streamed words: 2-bit counter goes 1,2,3,0,1.
      do_reset();
      sym_en = 1'b1;
      for (int w = 0; w < 5; w++) begin
         din = 8'($urandom);
         din_valid = 1'b1;
         acc = 1'b0;
         for (int t = 0; t < 8 && !acc; t++) begin
            acc = model_rdy();
            tick();
         end
         chk("stream_accept", acc, 1'b1);
      end
      din_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("wrap_cnt_w2", byte_cnt2, 2'd1);
      chk("wrap_cnt_w8", byte_cnt, 8'd5);

      // Random source/strobe run; source holds din until accepted.
      din_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         sym_en = ($urandom_range(0, 3) != 0);
         acc = model_rdy() && din_valid;
         tick();
         if (acc || !din_valid) begin
            din_valid = ($urandom_range(0, 2) != 0);
            din = 8'($urandom);
         end
      end
      din_valid = 1'b0;
      sym_en = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("rand_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
